uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Transmit scheduler between the processor's UART byte port and UART_top.
- Buffers bytes written by the processor in a FIFO and hands them one at a time to the UART transmitter, using UART_top's TE (transmitter empty) handshake.
- Gives the processor a non-blocking ready signal, so software no longer spins on TE for every byte.
- Sits in top between dsd_processor (UART_load/UART_din/UART_TE) and UART_top (UART_wr/din/TE).

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, log2(DEPTH); FIFO pointer width.
- BUSY_TO, 4, max cycles to wait for TE to fall after a load before assuming the byte was taken; at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  processor byte-write strobe (from UART_load).
- wr_data  in  8  processor byte (from UART_din).
- ready  out  1  FIFO not full (to processor UART_TE input).
- flush  in  1  synchronous FIFO clear.
- uart_te  in  1  UART_top TE; 1 = transmitter idle.
- uart_wr  out  1  one-cycle load pulse to UART_top UART_wr.
- uart_din  out  8  byte to UART_top din; valid while uart_wr = 1.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high): FIFO pointers = 0, level = 0, ready = 1, uart_wr = 0, uart_din = 8'h00, overflow = 0, FSM = IDLE, timeout counter = 0.
- FIFO:
  - Circular buffer with AW-bit pointers and an (AW+1)-bit count.
  - full = (count == DEPTH); empty = (count == 0); ready = ~full, derived from registered state only.
  - Push: wr_en && ~full. Data is stored at wptr and wptr wraps mod DEPTH.
  - wr_en while full: byte dropped, overflow set to 1. Full is judged at the start of the cycle, so a same-cycle pop does not rescue the write.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push into an empty FIFO cannot pop in the same cycle; the earliest pop is the next cycle.
- FSM:
  - IDLE: if ~empty && uart_te, pop the head, drive uart_wr = 1 and uart_din = head (both registered, valid the next cycle), go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: uart_wr = 0 and uart_din holds. If uart_te == 0, go to WAIT_DONE. If uart_te stays 1 for BUSY_TO cycles, go to IDLE (timeout). The counter clears on entry.
  - WAIT_DONE: if uart_te == 1, go to IDLE.
- Latency: byte written at cycle N into an empty FIFO with FSM IDLE and uart_te = 1 gives uart_wr = 1 and uart_din = byte in cycle N+1. Exactly one uart_wr pulse per byte; pulses are never back-to-back.
- flush:
  - Clears the pointers, count and overflow.
  - A push in the same cycle is discarded.
  - Does not abort an in-flight byte; the FSM finishes its handshake normally.
- Reset mid-transfer: the FSM returns to IDLE and uart_wr drops immediately; the pending byte is lost.
- level always equals count.

Optional Feature:
- Macro: UART_TX_CRLF_EN.
- Defined:
  - When the FIFO head is 8'h0A and the last byte sent was not 8'h0D, IDLE sends 8'h0D without popping, then sends 8'h0A on the next IDLE pass.
  - A "last sent" register (reset 8'h00) tracks the previous byte.
  - level does not count the inserted CR.
- Undefined: bytes pass through verbatim; no extra register.

Test Plan:
- Reset, uart_te = 1, write 8'h41 at cycle N -> uart_wr = 1 with uart_din = 8'h41 at N+1; level goes 1 then 0; ready = 1 throughout.
- Write 3 bytes back-to-back (8'h31, 8'h32, 8'h33); UART model drops TE for 10 cycles after each load -> three uart_wr pulses in order, each only after TE returns to 1.
- Hold uart_te = 0 and write 17 bytes with DEPTH = 16 -> ready = 0 after the 16th; the 17th is dropped; overflow = 1; level = 16. Then pulse flush -> level = 0, overflow = 0, ready = 1.
- Load a byte while uart_te stays 1 permanently -> FSM returns to IDLE after BUSY_TO = 4 cycles; the next byte is sent; no hang.
- Assert reset in WAIT_DONE with 5 bytes queued -> uart_wr = 0, level = 0, ready = 1 immediately; no pulses afterwards.
- With UART_TX_CRLF_EN defined, write 8'h48, 8'h0A -> uart_din sequence 8'h48, 8'h0D, 8'h0A. Write 8'h0D, 8'h0A -> exactly 8'h0D, 8'h0A.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Interface bundling the processor byte port, the UART_top transmit
// handshake and the scheduler status outputs of uart_tx_sched.
// The master modport is the side that drives the scheduler's inputs
// (processor plus UART_top). The slave modport is the scheduler itself.
interface uart_tx_sched_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ready;
  logic          flush;
  logic          uart_te;
  logic          uart_wr;
  logic [7:0]    uart_din;
  logic [AW:0]   level;
  logic          overflow;

  modport master (
    output wr_en,
    output wr_data,
    output flush,
    output uart_te,
    input  ready,
    input  uart_wr,
    input  uart_din,
    input  level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    input  flush,
    input  uart_te,
    output ready,
    output uart_wr,
    output uart_din,
    output level,
    output overflow
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit scheduler between the processor UART byte port
// and UART_top. Bytes written by the processor are queued in a circular
// FIFO and handed to the transmitter one at a time using the TE
// (transmitter empty) handshake, so software only stalls when the FIFO
// is full.
//
// Optional feature: define UART_TX_CRLF_EN to insert a CR (8'h0D) in
// front of every LF (8'h0A) that is not already preceded by a CR.
// Without the macro, bytes pass through verbatim.
module uart_tx_sched #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int BUSY_TO = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_sched_if.slave  bus
);

  // Timeout counter only needs to hold 0..BUSY_TO-1.
  localparam int TW = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          overflow_q;

  // Transmit FSM state
  state_t        state_q;
  state_t        state_d;
  logic [TW-1:0] to_cnt_q;
  logic [TW-1:0] to_cnt_d;
  logic          wr_q;
  logic [7:0]    din_q;

  // Decoded control
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          launch;
  logic [7:0]    head;
  logic [7:0]    send_byte;

`ifdef UART_TX_CRLF_EN
  logic [7:0]    last_sent;
`endif

  // Full/empty come from registered state only, so a same-cycle pop can
  // never make room for a write and ready has no combinational path from
  // the inputs.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.wr_en && !full && !bus.flush;
  assign head  = mem[rptr];

  // Next-state logic: decide when to launch a byte and track the TE
  // handshake that follows each load pulse.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    launch    = 1'b0;
    pop       = 1'b0;
    send_byte = head;
    case (state_q)
      IDLE: begin
        if (!empty && bus.uart_te) begin
          launch   = 1'b1;
          state_d  = WAIT_BUSY;
          to_cnt_d = '0;
`ifdef UART_TX_CRLF_EN
          // A bare LF gets a CR sent first; the LF stays at the head and
          // goes out on the next pass, when last_sent is already CR.
          if (head == 8'h0A && last_sent != 8'h0D) begin
            send_byte = 8'h0D;
            pop       = 1'b0;
          end else begin
            pop       = 1'b1;
          end
`else
          pop = 1'b1;
`endif
        end
      end
      WAIT_BUSY: begin
        // TE falling means the transmitter accepted the byte. If it never
        // falls, give up after BUSY_TO cycles instead of hanging.
        if (!bus.uart_te) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.uart_te) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM register plus the registered load pulse and data byte; uart_din
  // only changes when a new byte is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      wr_q     <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      wr_q     <= launch;
      if (launch) begin
        din_q <= send_byte;
      end
    end
  end

`ifdef UART_TX_CRLF_EN
  // Remember the most recent byte handed to the transmitter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_sent <= 8'h00;
    end else if (launch) begin
      last_sent <= send_byte;
    end
  end
`endif

  // FIFO pointers, occupancy and sticky overflow; flush wins over
  // everything, including a write in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Byte storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.wr_data;
    end
  end

  assign bus.ready    = !full;
  assign bus.level    = count;
  assign bus.overflow = overflow_q;
  assign bus.uart_wr  = wr_q;
  assign bus.uart_din = din_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a vector table for the basic
// load/timeout behaviour, plus hand-written sequences driven against a
// small UART_top model for the handshake, overflow/flush, reset and
// (with UART_TX_CRLF_EN) CR insertion cases.
module tb_uart_tx_sched;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       te;
    logic       exp_wr;
    logic [7:0] exp_din;
    logic [4:0] exp_level;
    logic       exp_ready;
    logic       exp_ovf;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // UART model: drops TE for 10 cycles after each observed load pulse
  logic       model_en;
  logic       model_te;
  int         model_busy;
  logic       te_drv;
  logic       prev_wr;
  logic [7:0] pulse_q [$];

  vec_t vecs [8];

  uart_tx_sched_if #(.AW(4)) bus ();

  uart_tx_sched #(.DEPTH(16), .AW(4), .BUSY_TO(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.uart_te = model_en ? model_te : te_drv;

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wr_en, input logic [7:0] data,
                                input logic flush);
    bus.wr_en   = wr_en;
    bus.wr_data = data;
    bus.flush   = flush;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] data);
    apply_stimulus(1'b1, data, 1'b0);
    tick();
    apply_stimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pulse_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output(name, 32'(pulse_q.size()), 32'(n));
  endtask

  // Pulse logger and UART model, sampled just after each rising edge
  initial begin
    model_te   = 1'b1;
    model_busy = 0;
    prev_wr    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.uart_wr) begin
        pulse_q.push_back(bus.uart_din);
        check_output("no_back_to_back", 32'(prev_wr), 32'(0));
        if (model_en) begin
          check_output("pulse_after_te", 32'(model_te), 32'(1));
        end
      end
      prev_wr = bus.uart_wr;
      if (model_en && bus.uart_wr) begin
        model_te   = 1'b0;
        model_busy = 10;
      end else if (model_busy > 0) begin
        model_busy = model_busy - 1;
        if (model_busy == 0) begin
          model_te = 1'b1;
        end
      end
    end
  end

  initial begin
    int base;
    logic [15:0] act;
    logic [15:0] exp;
    checks   = 0;
    errors   = 0;
    model_en = 1'b0;
    te_drv   = 1'b1;
    reset    = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b0);

    // Table: single byte latency, then BUSY_TO timeout with TE stuck at 1
    //            wr    data    fl    te    uwr   din     lvl    rdy   ovf
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h41, 5'd0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 5'd1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 5'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h55, 5'd0, 1'b1, 1'b0};

    do_reset();
    check_output("reset_state",
                 32'({bus.uart_wr, bus.uart_din, bus.level, bus.ready, bus.overflow}),
                 32'({1'b0, 8'h00, 5'd0, 1'b1, 1'b0}));

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].wr_en, vecs[i].wr_data, vecs[i].flush);
      te_drv = vecs[i].te;
      tick();
      act = {bus.uart_wr, bus.uart_din, bus.level, bus.ready, bus.overflow};
      exp = {vecs[i].exp_wr, vecs[i].exp_din, vecs[i].exp_level,
             vecs[i].exp_ready, vecs[i].exp_ovf};
      check_output($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end
    apply_stimulus(1'b0, 8'h00, 1'b0);

    // Three back-to-back bytes against the TE model
    do_reset();
    model_en = 1'b1;
    base = pulse_q.size();
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    wait_pulses(base + 3, 200, "three_pulses");
    if (pulse_q.size() >= base + 3) begin
      check_output("byte0", 32'(pulse_q[base]),     32'(8'h31));
      check_output("byte1", 32'(pulse_q[base + 1]), 32'(8'h32));
      check_output("byte2", 32'(pulse_q[base + 2]), 32'(8'h33));
    end
    for (int i = 0; i < 20; i++) tick();
    check_output("no_extra_pulse", 32'(pulse_q.size()), 32'(base + 3));

    // Overflow with TE held low, then flush
    model_en = 1'b0;
    te_drv   = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b0);
      tick();
      if (i == 15) begin
        check_output("full_at_16",
                     32'({bus.level, bus.ready, bus.overflow}),
                     32'({5'd16, 1'b0, 1'b0}));
      end
    end
    check_output("overflow_17",
                 32'({bus.level, bus.ready, bus.overflow}),
                 32'({5'd16, 1'b0, 1'b1}));
    apply_stimulus(1'b0, 8'h00, 1'b1);
    tick();
    check_output("after_flush",
                 32'({bus.level, bus.ready, bus.overflow}),
                 32'({5'd0, 1'b1, 1'b0}));
    apply_stimulus(1'b1, 8'hAA, 1'b1);
    tick();
    check_output("flush_drops_push", 32'(bus.level), 32'(0));
    apply_stimulus(1'b1, 8'hBB, 1'b0);
    tick();
    check_output("push_after_flush", 32'(bus.level), 32'(1));
    apply_stimulus(1'b0, 8'h00, 1'b0);

    // Reset while waiting for TE to return, with five bytes queued
    te_drv = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    model_en = 1'b1;
    for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
    tick();
    check_output("queued_before_reset", 32'(bus.level), 32'(5));
    #3;
    reset = 1'b1;
    #1;
    check_output("reset_mid_transfer",
                 32'({bus.uart_wr, bus.level, bus.ready}),
                 32'({1'b0, 5'd0, 1'b1}));
    tick();
    reset = 1'b0;
    base = pulse_q.size();
    for (int i = 0; i < 30; i++) tick();
    check_output("no_pulse_after_reset", 32'(pulse_q.size()), 32'(base));

`ifdef UART_TX_CRLF_EN
    // CR insertion in front of a bare LF, none when CR already present
    do_reset();
    base = pulse_q.size();
    write_byte(8'h48);
    write_byte(8'h0A);
    wait_pulses(base + 3, 300, "crlf_pulses");
    if (pulse_q.size() >= base + 3) begin
      check_output("crlf_h",  32'(pulse_q[base]),     32'(8'h48));
      check_output("crlf_cr", 32'(pulse_q[base + 1]), 32'(8'h0D));
      check_output("crlf_lf", 32'(pulse_q[base + 2]), 32'(8'h0A));
    end
    for (int i = 0; i < 20; i++) tick();
    base = pulse_q.size();
    write_byte(8'h0D);
    write_byte(8'h0A);
    wait_pulses(base + 2, 300, "crlf_pair_pulses");
    for (int i = 0; i < 30; i++) tick();
    check_output("crlf_pair_count", 32'(pulse_q.size()), 32'(base + 2));
    if (pulse_q.size() >= base + 2) begin
      check_output("pair_cr", 32'(pulse_q[base]),     32'(8'h0D));
      check_output("pair_lf", 32'(pulse_q[base + 1]), 32'(8'h0A));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
